sobel_uc: RTL and testbench

- Control unit that sequences one full image through the sobel datapath: serial reception of the input image, per-pixel sobel computation, and serial transmission of each result byte.
- Drives rx_enable, sobel_calcula, tx_partida and tx_enable of the sobel datapath.
- Observes rx_pronto, tx_pronto and sobel_fim_imagem.
- Sits beside the datapath in the top level and takes start/abort from board buttons.

---
 rtl/sobel_uc.sv | 148 ++++++++++++++
 tb/tb_sobel_uc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_uc.sv
// Control unit for the sobel datapath: receives one image serially, then runs
// the compute/transmit loop for each output pixel until the datapath reports the last one.
module sobel_uc #(
  parameter int unsigned LARGURA    = 64,
  parameter int unsigned ALTURA     = 48,
  parameter int unsigned LAT_CALC   = 2,
  parameter int unsigned TIMEOUT_TX = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        abortar,
  input  logic        rx_pronto,
  input  logic        tx_pronto,
  input  logic        sobel_fim_imagem,
  output logic        rx_enable,
  output logic        sobel_calcula,
  output logic        tx_partida,
  output logic        tx_enable,
  output logic        pronto,
  output logic        erro,
  output logic [15:0] db_bytes_rx,
  output logic [3:0]  db_estado
);

  localparam int unsigned N_BYTES = LARGURA * ALTURA;
  localparam int unsigned LW      = (LAT_CALC > 1) ? $clog2(LAT_CALC) : 1;
  localparam int unsigned TW      = $clog2(TIMEOUT_TX + 1);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    RECEBE      = 4'd1,
    CALCULA     = 4'd2,
    ESPERA_CALC = 4'd3,
    TRANSMITE   = 4'd4,
    ESPERA_TX   = 4'd5,
    FIM         = 4'd6,
    ERRO        = 4'd7
  } estado_t;

  estado_t        estado;
  logic [LW-1:0]  cnt_lat;
  logic [TW-1:0]  cnt_tmo;
  logic [15:0]    bytes_inc;
  logic [TW-1:0]  tmo_inc;

  assign bytes_inc = db_bytes_rx + 16'd1;
  assign tmo_inc   = cnt_tmo + TW'(1);
  assign db_estado = estado;

  // Pulse outputs default low every cycle; they are raised on the transition into their state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= OCIOSO;
      rx_enable     <= 1'b0;
      sobel_calcula <= 1'b0;
      tx_partida    <= 1'b0;
      tx_enable     <= 1'b0;
      pronto        <= 1'b0;
      erro          <= 1'b0;
      db_bytes_rx   <= '0;
      cnt_lat       <= '0;
      cnt_tmo       <= '0;
    end else begin
      sobel_calcula <= 1'b0;
      tx_partida    <= 1'b0;
      pronto        <= 1'b0;
      if (abortar && (estado != OCIOSO)) begin
        estado    <= OCIOSO;
        rx_enable <= 1'b0;
        tx_enable <= 1'b0;
        cnt_lat   <= '0;
        cnt_tmo   <= '0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (iniciar) begin
              estado      <= RECEBE;
              rx_enable   <= 1'b1;
              db_bytes_rx <= '0;
              erro        <= 1'b0;
            end
          end
          RECEBE: begin
            if (rx_pronto) begin
              db_bytes_rx <= bytes_inc;
              if (bytes_inc == 16'(N_BYTES)) begin
                estado        <= CALCULA;
                rx_enable     <= 1'b0;
                sobel_calcula <= 1'b1;
              end
            end
          end
          CALCULA: begin
            estado  <= ESPERA_CALC;
            cnt_lat <= LW'(LAT_CALC - 1);
          end
          ESPERA_CALC: begin
            if (cnt_lat == '0) begin
              estado     <= TRANSMITE;
              tx_partida <= 1'b1;
              tx_enable  <= 1'b1;
            end else begin
              cnt_lat <= cnt_lat - LW'(1);
            end
          end
          TRANSMITE: begin
            estado  <= ESPERA_TX;
            cnt_tmo <= '0;
          end
          // tx_pronto takes precedence over a timeout expiring in the same cycle
          ESPERA_TX: begin
            if (tx_pronto) begin
              tx_enable <= 1'b0;
              cnt_tmo   <= '0;
              if (sobel_fim_imagem) begin
                estado <= FIM;
                pronto <= 1'b1;
              end else begin
                estado        <= CALCULA;
                sobel_calcula <= 1'b1;
              end
            end else if (tmo_inc == TW'(TIMEOUT_TX)) begin
              estado    <= ERRO;
              erro      <= 1'b1;
              tx_enable <= 1'b0;
              cnt_tmo   <= '0;
            end else begin
              cnt_tmo <= tmo_inc;
            end
          end
          FIM: begin
            estado <= OCIOSO;
          end
          ERRO: begin
            if (iniciar) begin
              estado <= OCIOSO;
            end
          end
          default: begin
            estado <= OCIOSO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_uc.sv
// Directed bench for sobel_uc on a 4x4 image: reception, compute/transmit loop,
// timeout, abort and stray-pulse handling.
module tb_sobel_uc;

  logic        clk;
  logic        rst_n;
  logic        iniciar;
  logic        abortar;
  logic        rx_pronto;
  logic        tx_pronto;
  logic        fim;
  logic        rx_enable;
  logic        sobel_calcula;
  logic        tx_partida;
  logic        tx_enable;
  logic        pronto;
  logic        erro;
  logic [15:0] db_bytes_rx;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int n_calc = 0;
  int n_txp  = 0;
  int n_pron = 0;

  sobel_uc #(
    .LARGURA(4), .ALTURA(4), .LAT_CALC(2), .TIMEOUT_TX(50)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .iniciar(iniciar),
    .abortar(abortar),
    .rx_pronto(rx_pronto),
    .tx_pronto(tx_pronto),
    .sobel_fim_imagem(fim),
    .rx_enable(rx_enable),
    .sobel_calcula(sobel_calcula),
    .tx_partida(tx_partida),
    .tx_enable(tx_enable),
    .pronto(pronto),
    .erro(erro),
    .db_bytes_rx(db_bytes_rx),
    .db_estado(db_estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for the full-image run
  always @(negedge clk) begin
    if (sobel_calcula) n_calc <= n_calc + 1;
    if (tx_partida)    n_txp  <= n_txp + 1;
    if (pronto)        n_pron <= n_pron + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, {26'd0, rx_enable, sobel_calcula, tx_partida, tx_enable, pronto, erro}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; iniciar = 1'b0; abortar = 1'b0;
    rx_pronto = 1'b0; tx_pronto = 1'b0; fim = 1'b0;

    // Reset
    tick(3);
    chk_idle("rst");
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_bytes", 32'(db_bytes_rx), 32'd0);
    rst_n = 1'b1;
    tick(20);
    chk_idle("idle20");
    chk("idle20_estado", 32'(db_estado), 32'd0);

    // Reception, 10 cycles between bytes
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    chk("rx_start_en", 32'(rx_enable), 32'd1);
    chk("rx_start_estado", 32'(db_estado), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      rx_pronto = 1'b1; tick(1); rx_pronto = 1'b0;
      chk("rx_count", 32'(db_bytes_rx), 32'(i));
      if (i < 16) begin
        chk("rx_en_hold", 32'(rx_enable), 32'd1);
        tick(9);
        chk("rx_en_gap", 32'(rx_enable), 32'd1);
      end
    end
    chk("rx_done_en", 32'(rx_enable), 32'd0);

    // Compute/transmit loop over 4 pixels
    for (int p = 1; p <= 4; p++) begin
      chk("calc_pulse", 32'(sobel_calcula), 32'd1);
      chk("calc_estado", 32'(db_estado), 32'd2);
      chk("calc_txen", 32'(tx_enable), 32'd0);
      tick(1);
      chk("calc_one_cycle", 32'(sobel_calcula), 32'd0);
      if (p == 2) fim = 1'b1;
      chk("lat1_txp", 32'(tx_partida), 32'd0);
      tick(1);
      fim = 1'b0;
      chk("lat2_txp", 32'(tx_partida), 32'd0);
      tick(1);
      chk("txp_pulse", 32'(tx_partida), 32'd1);
      chk("txp_estado", 32'(db_estado), 32'd4);
      chk("txp_txen", 32'(tx_enable), 32'd1);
      tick(1);
      chk("esp_estado", 32'(db_estado), 32'd5);
      chk("esp_txp", 32'(tx_partida), 32'd0);
      chk("esp_txen", 32'(tx_enable), 32'd1);
      tick(29);
      if (p == 4) fim = 1'b1;
      tx_pronto = 1'b1; tick(1); tx_pronto = 1'b0; fim = 1'b0;
    end
    chk("fim_pronto", 32'(pronto), 32'd1);
    chk("fim_estado", 32'(db_estado), 32'd6);
    tick(1);
    chk("fim_pronto_off", 32'(pronto), 32'd0);
    chk("fim_idle_estado", 32'(db_estado), 32'd0);
    chk("fim_bytes_hold", 32'(db_bytes_rx), 32'd16);
    chk("n_calc", 32'(n_calc), 32'd4);
    chk("n_txp", 32'(n_txp), 32'd4);
    chk("n_pronto", 32'(n_pron), 32'd1);

    // Transmit timeout
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    chk("to_bytes_clr", 32'(db_bytes_rx), 32'd0);
    rx_pronto = 1'b1; tick(16); rx_pronto = 1'b0;
    chk("to_estado_calc", 32'(db_estado), 32'd2);
    tick(4);
    chk("to_esp", 32'(db_estado), 32'd5);
    tick(49);
    chk("to_e49_estado", 32'(db_estado), 32'd5);
    chk("to_e49_erro", 32'(erro), 32'd0);
    tick(1);
    chk("to_erro", 32'(erro), 32'd1);
    chk("to_estado", 32'(db_estado), 32'd7);
    chk("to_txen", 32'(tx_enable), 32'd0);
    tick(5);
    chk("to_stay", 32'(db_estado), 32'd7);
    abortar = 1'b1; tick(1); abortar = 1'b0;
    chk("to_abort_estado", 32'(db_estado), 32'd0);
    chk("to_abort_erro", 32'(erro), 32'd1);
    tick(3);
    chk("to_sticky", 32'(erro), 32'd1);
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    chk("to_restart_erro", 32'(erro), 32'd0);
    chk("to_restart_estado", 32'(db_estado), 32'd1);

    // Abort during reception after 7 bytes
    for (int i = 0; i < 7; i++) begin
      rx_pronto = 1'b1; tick(1); rx_pronto = 1'b0; tick(1);
    end
    chk("ab_bytes7", 32'(db_bytes_rx), 32'd7);
    abortar = 1'b1; tick(1); abortar = 1'b0;
    chk("ab_estado", 32'(db_estado), 32'd0);
    chk("ab_rxen", 32'(rx_enable), 32'd0);
    chk("ab_bytes_keep", 32'(db_bytes_rx), 32'd7);

    // Stray pulses while idle
    for (int i = 0; i < 3; i++) begin
      rx_pronto = 1'b1; tick(1); rx_pronto = 1'b0; tick(1);
    end
    tx_pronto = 1'b1; tick(1); tx_pronto = 1'b0;
    chk("stray_bytes", 32'(db_bytes_rx), 32'd7);
    chk("stray_estado", 32'(db_estado), 32'd0);
    chk_idle("stray");

    // tx_pronto coincident with timeout expiry
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
    rx_pronto = 1'b1; tick(16); rx_pronto = 1'b0;
    tick(4);
    chk("co_esp", 32'(db_estado), 32'd5);
    tick(49);
    tx_pronto = 1'b1; tick(1); tx_pronto = 1'b0;
    chk("co_estado", 32'(db_estado), 32'd2);
    chk("co_calc", 32'(sobel_calcula), 32'd1);
    chk("co_erro", 32'(erro), 32'd0);
    abortar = 1'b1; tick(1); abortar = 1'b0;
    chk("co_abort", 32'(db_estado), 32'd0);
    chk("co_abort_bytes", 32'(db_bytes_rx), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
